// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizes and filters the PS/2 clock, shifts frame bits
// into an external 10-bit shift register and validates stop/odd parity before publishing a byte.
module ps2_rx_ctrl #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic [9:0] q,
  output logic       pulseVal,
  output logic       sdi,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_Q, CHECK} state_t;

  state_t          state;
  logic            c_s1, c_s2, d_s1, d_s2;
  logic            filt, filt_prev;
  logic [FW-1:0]   filt_cnt;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   timer;
  logic            fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Any return to the current filtered level restarts the qualification count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt;
      if (c_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt     <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt;

  // The timeout check precedes the fall check so a coincident fall is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      timer     <= '0;
      pulseVal  <= 1'b0;
      sdi       <= 1'b0;
      data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pulseVal  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && !d_s2) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            timer   <= '0;
          end
        end
        SHIFT: begin
          if (timer == TW'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (fall) begin
            pulseVal <= 1'b1;
            sdi      <= d_s2;
            bit_cnt  <= bit_cnt + 1'b1;
            timer    <= '0;
            if (bit_cnt == 4'd9) state <= WAIT_Q;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_Q: state <= CHECK;
        CHECK: begin
          if (q[9] && (^q[8:0])) begin
            data    <= q[7:0];
            rx_done <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: models the external shift register and PS/2 line timing,
// then checks pulse counts, serial bits, strobe timing and received bytes.
module tb_ps2_rx_ctrl;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [9:0] q = '0;
  logic       pulseVal, sdi, rx_done, frame_err;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulseCount = 0, rxCount = 0, errCount = 0, bothCount = 0;
  int lastPulseCyc = 0, rxCyc = 0, errCyc = 0;
  int pBase = 0, rBase = 0, eBase = 0;
  logic sdiLog [0:511];

  ps2_rx_ctrl #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .q(q),
    .pulseVal(pulseVal), .sdi(sdi), .data(data), .rx_done(rx_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pulseVal) q <= {sdi, q[9:1]};
  end

  // Outputs are observed on the falling edge, half a cycle after they settle.
  always @(negedge clk) begin
    if (pulseVal) begin
      if (pulseCount < 512) sdiLog[pulseCount] = sdi;
      lastPulseCyc = cyc;
      pulseCount++;
    end
    if (rx_done) begin
      rxCount++;
      rxCyc = cyc;
    end
    if (frame_err) begin
      errCount++;
      errCyc = cyc;
    end
    if (rx_done && frame_err) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic mark();
    pBase = pulseCount;
    rBase = rxCount;
    eBase = errCount;
  endtask

  // Drives the first nbits of {stop, parity, byte, start} onto the lines, LSB first.
  task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] frame;
    frame = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      repeat (10) @(negedge clk);
      ps2c = 1'b0;
      repeat (20) @(negedge clk);
      ps2c = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [9:0] sdiVec(input int base);
    logic [9:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v[i] = sdiLog[base + i];
    return v;
  endfunction

  initial begin
    repeat (5) @(negedge clk);
    checkOutput("rst_pulseVal", {31'd0, pulseVal}, 32'd0);
    checkOutput("rst_sdi", {31'd0, sdi}, 32'd0);
    checkOutput("rst_data", {24'd0, data}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);

    mark();
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("1c_pulses", pulseCount - pBase, 32'd10);
    checkOutput("1c_sdi_bits", {22'd0, sdiVec(pBase)}, 32'h21C);
    checkOutput("1c_rx_count", rxCount - rBase, 32'd1);
    checkOutput("1c_rx_latency", rxCyc - lastPulseCyc, 32'd2);
    checkOutput("1c_data", {24'd0, data}, 32'h1C);
    checkOutput("1c_err_count", errCount - eBase, 32'd0);

    mark();
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("f0_err_count", errCount - eBase, 32'd1);
    checkOutput("f0_rx_count", rxCount - rBase, 32'd0);
    checkOutput("f0_data_kept", {24'd0, data}, 32'h1C);

    mark();
    applyStimulus(8'h33, 1'b1, 1'b0, 11);
    checkOutput("stop0_err_count", errCount - eBase, 32'd1);
    mark();
    applyStimulus(8'h5A, 1'b1, 1'b1, 11);
    checkOutput("5a_rx_count", rxCount - rBase, 32'd1);
    checkOutput("5a_data", {24'd0, data}, 32'h5A);

    mark();
    applyStimulus(8'h0F, 1'b1, 1'b1, 5);
    repeat (TIMEOUT + 50) @(negedge clk);
    checkOutput("to_pulses", pulseCount - pBase, 32'd4);
    checkOutput("to_err_count", errCount - eBase, 32'd1);
    checkOutput("to_err_delay", errCyc - lastPulseCyc, TIMEOUT);
    checkOutput("to_rx_count", rxCount - rBase, 32'd0);
    mark();
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("29_rx_count", rxCount - rBase, 32'd1);
    checkOutput("29_data", {24'd0, data}, 32'h29);

    mark();
    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (FILT_LEN - 1) @(negedge clk);
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_pulses", pulseCount - pBase, 32'd0);
    checkOutput("glitch_err_count", errCount - eBase, 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("post_glitch_pulses", pulseCount - pBase, 32'd10);
    checkOutput("post_glitch_data", {24'd0, data}, 32'h1C);

    applyStimulus(8'hA5, 1'b1, 1'b1, 4);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_data", {24'd0, data}, 32'h00);
    checkOutput("midrst_pulseVal", {31'd0, pulseVal}, 32'd0);
    rst = 1'b1;
    mark();
    repeat (TIMEOUT + 50) @(negedge clk);
    checkOutput("midrst_err_after", errCount - eBase, 32'd0);
    checkOutput("midrst_rx_after", rxCount - rBase, 32'd0);
    checkOutput("midrst_pulses_after", pulseCount - pBase, 32'd0);
    checkOutput("midrst_outputs", {28'd0, pulseVal, sdi, rx_done, frame_err}, 32'd0);
    checkOutput("never_both_strobes", bothCount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
